kws_mul_share_arb: RTL and testbench
====================================

Name: kws_mul_share_arb

Overview:
- Time-shares one unsigned 12x10 multiplier (22-bit product) between NUM_REQ requesters in the KWS feature/MAC datapath.
- Grants requests round-robin and accepts at most one operand pair per cycle.
- Pushes each operand pair through a LATENCY-stage pipelined multiply, carrying a requester tag.
- Returns each product as a one-cycle pulse to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 2, cycles from accepted request to result pulse (1..4).
- A_WIDTH, 12, operand A width (unsigned).
- B_WIDTH, 10, operand B width (unsigned).
- P_WIDTH, 22, product width; fixed at A_WIDTH+B_WIDTH.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ap_ce  in  1  clock enable; low freezes the whole block.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- req_a  in  NUM_REQ*A_WIDTH  flattened operand A; requester i uses bits [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  flattened operand B; requester i uses bits [i*B_WIDTH +: B_WIDTH].
- res_valid  out  NUM_REQ  one-hot, one-cycle result pulse to the owning requester.
- res_p  out  P_WIDTH  product; meaningful only when any res_valid bit is high.
- busy  out  1  high while any pipeline stage holds a valid entry.
- op_count  out  32  number of accepted requests; wraps 0xFFFFFFFF->0.

Behaviour:
- Reset values (asynchronous on ap_rst_n low): res_valid=0, res_p=0, busy=0, op_count=0, round-robin pointer=0, all stage valid bits and tags cleared.
- req_ready is combinational from req_valid, the pointer and ap_ce. It is 0 while ap_rst_n is low.
- Grant rule:
  - When ap_ce=1, grant the first index i with req_valid[i]=1, searching from pointer upward and wrapping modulo NUM_REQ.
  - At most one req_ready bit is high.
  - If no req_valid bit is high, req_ready=0.
- Pointer: after a grant to index g, pointer becomes (g+1) mod NUM_REQ. With no grant, pointer holds.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ cycles of ap_ce=1.
- Requesters must hold req_a/req_b stable while req_valid is high and ungranted. Dropping req_valid before grant is legal; nothing is issued.
- Pipeline:
  - Stage 1 registers the selected a, b, the tag (index) and valid.
  - The product is computed as $unsigned(a)*$unsigned(b), full P_WIDTH, with no truncation or saturation.
  - The product is carried through the remaining LATENCY-1 stages.
- Latency: for a request accepted at edge k, res_valid[tag] and res_p are high/valid for exactly the cycle after edge k+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Throughput: one result per cycle. Results emerge in acceptance order. There is no result backpressure; requesters must sample on the pulse.
- ap_ce=0:
  - req_ready=0.
  - Pointer, pipeline, op_count, res_valid and res_p all hold their values; a res_valid pulse stays asserted until ap_ce returns.
  - Requesters must qualify res_valid with ap_ce.
- op_count increments by 1 on every accepted transfer.
- busy = OR of all stage valid bits.
- Reset mid-operation: all in-flight entries are discarded and no result pulse is produced for them. After ap_rst_n deasserts, the first grant search starts at index 0.
- Simultaneous events: a new acceptance in the same cycle a result leaves the pipeline is normal operation. No bubble is inserted.
- Zero operands are legal (product 0). The maximum product is 4095*1023 = 4189185 = 0x3FEC01.

Test Plan:
1. Reset, then requester 2 alone sends a=100, b=7 -> req_ready=0b0100 the same cycle; res_valid=0b0100 with res_p=700 exactly 2 cycles later; op_count=1; busy high for 2 cycles.
2. All 4 requesters hold valid for 8 cycles with a=i+1, b=10 -> grants in order 0,1,2,3,0,1,2,3; results 10,20,30,40 repeat, each pulse on the matching res_valid bit; op_count=8.
3. Requester 0 sends a=4095, b=1023 -> res_p=0x3FEC01. Requester 3 sends a=0, b=1023 -> res_p=0.
4. Requesters 1 and 3 continuously valid, ap_ce dropped for 3 cycles mid-stream -> req_ready=0 and pipeline/res outputs frozen during the stall; the grant sequence resumes 1,3 alternating; no result lost or duplicated.
5. Two requests in flight, ap_rst_n pulsed low asynchronously between clock edges -> res_valid=0, busy=0, op_count=0 immediately; no stale result afterwards.
6. op_count preloaded to 0xFFFFFFFF via force, then one accepted request -> op_count=0.

Source files
------------

// File: rtl/kws_mul_share_arb.sv
// Round-robin arbiter sharing one unsigned A_WIDTH x B_WIDTH multiplier among
// NUM_REQ requesters; products return tagged, in order, after LATENCY cycles.
module kws_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    parameter int A_WIDTH = 12,
    parameter int B_WIDTH = 10,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_ce,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]           res_valid,
    output logic [P_WIDTH-1:0]           res_p,
    output logic                         busy,
    output logic [31:0]                  op_count
);

    localparam int TAG_W = $clog2(NUM_REQ);

    logic [TAG_W-1:0]                    r_ptr;
    logic [A_WIDTH-1:0]                  r_a;
    logic [B_WIDTH-1:0]                  r_b;
    logic [LATENCY-1:0]                  r_vld;
    logic [LATENCY-1:0][TAG_W-1:0]       r_tag;
    logic [31:0]                         r_op_cnt;

    logic [TAG_W-1:0]                    w_idx;
    logic [TAG_W-1:0]                    w_gnt_idx;
    logic [TAG_W-1:0]                    w_ptr_nxt;
    logic                                w_hit;
    logic                                w_found;
    logic                                w_fire;
    logic [A_WIDTH-1:0]                  w_sel_a;
    logic [B_WIDTH-1:0]                  w_sel_b;
    logic [P_WIDTH-1:0]                  w_prod;
    logic [P_WIDTH-1:0]                  w_res_p;

    // First valid requester at or after the pointer, wrapping around
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        w_hit     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx     = TAG_W'((int'(r_ptr) + k) % NUM_REQ);
            w_hit     = req_valid[w_idx] & ~w_found;
            w_gnt_idx = w_hit ? w_idx : w_gnt_idx;
            w_found   = w_found | w_hit;
        end
    end

    assign w_fire    = ap_rst_n & ap_ce & w_found;
    assign req_ready = w_fire ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;
    assign w_sel_a   = req_a[int'(w_gnt_idx) * A_WIDTH +: A_WIDTH];
    assign w_sel_b   = req_b[int'(w_gnt_idx) * B_WIDTH +: B_WIDTH];
    assign w_ptr_nxt = (w_gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + TAG_W'(1);
    assign w_prod    = P_WIDTH'(r_a) * P_WIDTH'(r_b);

    // Pointer advance, operand capture and valid/tag shift register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ptr <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_vld <= '0;
            r_tag <= '0;
        end else if (ap_ce) begin
            r_vld[0] <= w_fire;
            if (w_fire) begin
                r_ptr    <= w_ptr_nxt;
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                r_tag[0] <= w_gnt_idx;
            end
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    // Accepted-transfer counter, wraps naturally at 32 bits
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_op_cnt <= 32'd0;
        end else if (w_fire) begin
            r_op_cnt <= r_op_cnt + 32'd1;
        end
    end

    // Product registers; with one stage the product is taken straight off stage 1
    if (LATENCY == 1) begin : g_lat1
        assign w_res_p = w_prod;
    end else begin : g_latn
        logic [LATENCY-2:0][P_WIDTH-1:0] r_p;

        // Product shift register aligned with r_vld[1..LATENCY-1]
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                r_p <= '0;
            end else if (ap_ce) begin
                r_p[0] <= w_prod;
                for (int s = 1; s < LATENCY - 1; s++) begin
                    r_p[s] <= r_p[s-1];
                end
            end
        end

        assign w_res_p = r_p[LATENCY-2];
    end

    assign res_valid = r_vld[LATENCY-1] ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_tag[LATENCY-1]) : '0;
    assign res_p     = w_res_p;
    assign busy      = |r_vld;
    assign op_count  = r_op_cnt;

endmodule

// File: tb/tb_kws_mul_share_arb.sv
// Bench for kws_mul_share_arb: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of grants and scheduled results.
module tb_kws_mul_share_arb;

    localparam int N  = 4;
    localparam int L  = 2;
    localparam int AW = 12;
    localparam int BW = 10;
    localparam int PW = 22;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic              ap_ce;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_a;
    logic [N*BW-1:0]   req_b;
    logic [N-1:0]      res_valid;
    logic [PW-1:0]     res_p;
    logic              busy;
    logic [31:0]       op_count;

    kws_mul_share_arb #(.NUM_REQ(N), .LATENCY(L), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_ce(ap_ce),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_p(res_p), .busy(busy), .op_count(op_count)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pointer, enabled-edge count, counter, and results scheduled by due tick
    typedef struct { int due; int tag; logic [PW-1:0] p; } ent_t;
    ent_t        m_q[$];
    int          m_ptr  = 0;
    int          m_tick = 0;
    logic [31:0] m_cnt  = 32'd0;

    int           gnt_log[$];
    int           res_tag_log[$];
    logic [PW-1:0] res_p_log[$];

    function automatic int model_grant(input logic [N-1:0] v);
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && ((i - m_ptr + N) % N) < bd) begin
                bd = (i - m_ptr + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    always @(negedge ap_rst_n) begin
        m_q.delete();
        m_ptr  = 0;
        m_tick = 0;
        m_cnt  = 32'd0;
    end

    always @(posedge ap_clk) begin
        if (ap_rst_n === 1'b1 && ap_ce === 1'b1) begin
            int g;
            ent_t e;
            g = model_grant(req_valid);
            if (g >= 0) begin
                e.due = m_tick + L;
                e.tag = g;
                e.p   = PW'(int'(req_a[g*AW +: AW]) * int'(req_b[g*BW +: BW]));
                m_q.push_back(e);
                m_cnt = m_cnt + 32'd1;
                m_ptr = (g + 1) % N;
            end
            m_tick++;
            while (m_q.size() > 0 && m_q[0].due < m_tick) void'(m_q.pop_front());
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge ap_clk) begin
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_rv;
        int g;
        exp_rdy = '0;
        exp_rv  = '0;
        if (ap_rst_n === 1'b1 && ap_ce === 1'b1) begin
            g = model_grant(req_valid);
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        chk("req_ready", req_ready, exp_rdy);
        if (m_q.size() > 0 && m_q[0].due == m_tick) exp_rv[m_q[0].tag] = 1'b1;
        chk("res_valid", res_valid, exp_rv);
        if (exp_rv != '0) chk("res_p", res_p, m_q[0].p);
        chk("busy", busy, (m_q.size() > 0) ? 1 : 0);
        chk("op_count", op_count, m_cnt);
        if (ap_rst_n === 1'b1 && ap_ce === 1'b1) begin
            if ((req_valid & req_ready) != '0) gnt_log.push_back($clog2(req_ready));
            if (res_valid != '0) begin
                res_tag_log.push_back($clog2(res_valid));
                res_p_log.push_back(res_p);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input int a, input int b, input logic v);
        req_a[i*AW +: AW] = AW'(a);
        req_b[i*BW +: BW] = BW'(b);
        req_valid[i] = v;
    endtask

    task automatic reset_pulse();
        req_valid = '0;
        ap_ce = 1'b1;
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        res_tag_log.delete();
        res_p_log.delete();
    endtask

    function automatic int rand_op(input int maxv);
        int r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return maxv;
        return $urandom_range(0, maxv);
    endfunction

    logic [N-1:0] frz_rv;
    logic [PW-1:0] frz_p;
    logic [N-1:0] x;

    initial begin
        ap_rst_n = 1'b0;
        ap_ce = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        cyc(2);

        // Single request from requester 2
        set_req(2, 100, 7, 1'b1);
        #1 chk("t1_ready", req_ready, 4'b0100);
        @(posedge ap_clk);
        #1 req_valid = '0;
        chk("t1_busy_s1", busy, 1);
        chk("t1_rv_s1", res_valid, 0);
        @(posedge ap_clk);
        #1 chk("t1_rv", res_valid, 4'b0100);
        chk("t1_p", res_p, 700);
        chk("t1_busy_s2", busy, 1);
        @(posedge ap_clk);
        #1 chk("t1_rv_end", res_valid, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_cnt", op_count, 1);

        // All four requesters contend for eight cycles
        reset_pulse();
        clear_logs();
        for (int i = 0; i < N; i++) set_req(i, i + 1, 10, 1'b1);
        cyc(8);
        req_valid = '0;
        cyc(4);
        chk("t2_ngnt", gnt_log.size(), 8);
        chk("t2_nres", res_tag_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk("t2_gnt", gnt_log[k], k % 4);
            chk("t2_tag", res_tag_log[k], k % 4);
            chk("t2_p", res_p_log[k], 10 * (k % 4 + 1));
        end
        chk("t2_cnt", op_count, 8);

        // Extreme operands
        clear_logs();
        set_req(0, 4095, 1023, 1'b1);
        cyc(1);
        req_valid = '0;
        set_req(3, 0, 1023, 1'b1);
        cyc(1);
        req_valid = '0;
        cyc(4);
        chk("t3_nres", res_tag_log.size(), 2);
        chk("t3_tag0", res_tag_log[0], 0);
        chk("t3_max", res_p_log[0], 22'h3FEC01);
        chk("t3_tag1", res_tag_log[1], 3);
        chk("t3_zero", res_p_log[1], 0);

        // Clock-enable stall in the middle of a 1/3 stream
        reset_pulse();
        clear_logs();
        set_req(1, 5, 3, 1'b1);
        set_req(3, 7, 2, 1'b1);
        cyc(4);
        ap_ce = 1'b0;
        #1 chk("t4_ready_stall", req_ready, 0);
        frz_rv = res_valid;
        frz_p  = res_p;
        chk("t4_pulse_at_stall", (frz_rv != '0) ? 1 : 0, 1);
        repeat (3) begin
            @(posedge ap_clk);
            #1 chk("t4_frz_rv", res_valid, frz_rv);
            chk("t4_frz_p", res_p, frz_p);
            chk("t4_frz_cnt", op_count, 4);
        end
        ap_ce = 1'b1;
        cyc(4);
        req_valid = '0;
        cyc(4);
        chk("t4_ngnt", gnt_log.size(), 8);
        chk("t4_nres", res_tag_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk("t4_gnt", gnt_log[k], (k % 2 == 0) ? 1 : 3);
            chk("t4_tag", res_tag_log[k], (k % 2 == 0) ? 1 : 3);
            chk("t4_p", res_p_log[k], (k % 2 == 0) ? 15 : 14);
        end

        // Asynchronous reset with two products in flight
        reset_pulse();
        clear_logs();
        set_req(0, 9, 9, 1'b1);
        set_req(1, 8, 8, 1'b1);
        @(posedge ap_clk);
        @(posedge ap_clk);
        #3 ap_rst_n = 1'b0;
        #1 chk("t5_rv", res_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cnt", op_count, 0);
        chk("t5_ready", req_ready, 0);
        req_valid = '0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        clear_logs();
        cyc(5);
        chk("t5_nres", res_tag_log.size(), 0);
        chk("t5_cnt_after", op_count, 0);

        // Counter wrap
        force dut.r_op_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        cyc(1);
        release dut.r_op_cnt;
        #1 chk("t6_pre", op_count, 32'hFFFF_FFFF);
        set_req(2, 3, 3, 1'b1);
        cyc(1);
        req_valid = '0;
        chk("t6_wrap", op_count, 0);
        cyc(3);

        // Random traffic with stalls, drops and one mid-stream reset
        reset_pulse();
        for (int c = 0; c < 3000; c++) begin
            @(negedge ap_clk);
            x = (ap_rst_n && ap_ce) ? (req_valid & req_ready) : '0;
            @(posedge ap_clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !x[i]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
                end else begin
                    set_req(i, rand_op(4095), rand_op(1023),
                            ($urandom_range(0, 99) < ((c < 1000) ? 30 : 90)) ? 1'b1 : 1'b0);
                end
            end
            ap_ce = ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0;
            if (c == 1500) begin
                #2 ap_rst_n = 1'b0;
                #1 ap_rst_n = 1'b1;
            end
        end
        req_valid = '0;
        ap_ce = 1'b1;
        cyc(6);
        chk("drain_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
